// File: rtl/video_timing_gen_pkg.sv
// Shared types and constants for the raster timing generator.
package video_timing_pkg;

    // Width of both raster counters; a total of 2048 still fits.
    localparam int CNT_W     = 11;
    localparam int MAX_TOTAL = 2048;

    // Phase of one raster axis, visited in this order and wrapping BACK -> ACTIVE.
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // Default 640x480@60 timing.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;

    // True when every segment is at least one unit and the total fits the counter.
    function automatic bit timing_ok(input int act, input int fp, input int sw, input int bp);
        return (act >= 1) && (fp >= 1) && (sw >= 1) && (bp >= 1) &&
               ((act + fp + sw + bp) <= MAX_TOTAL);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers.
//
// Handshake: there is no valid/ready pair. i_en is a per-clock advance
// qualifier driven by the consumer side; every output is a register that
// describes the pixel currently on o_hcnt/o_vcnt, and all outputs hold
// while i_en is low (except the two start pulses, which drop to 0).
interface video_timing_gen_if;
    import video_timing_pkg::*;

    logic             i_en;
    logic [CNT_W-1:0] o_hcnt;
    logic [CNT_W-1:0] o_vcnt;
    logic             o_hsync;
    logic             o_vsync;
    logic             o_de;
    logic             o_line_start;
    logic             o_frame_start;
    // Debug view of the two axis phase FSMs.
    phase_e           dbg_hphase;
    phase_e           dbg_vphase;

    modport master (
        input  i_en,
        output o_hcnt, o_vcnt, o_hsync, o_vsync, o_de,
        output o_line_start, o_frame_start, dbg_hphase, dbg_vphase
    );

    modport slave (
        output i_en,
        input  o_hcnt, o_vcnt, o_hsync, o_vsync, o_de,
        input  o_line_start, o_frame_start, dbg_hphase, dbg_vphase
    );

endinterface

// File: rtl/video_timing_gen_axis_counter.sv
// One raster axis: a position counter plus its ACTIVE/FRONT/SYNC/BACK phase FSM.
// Reset parks the axis on its last position in BACK so the first step lands on 0.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output phase_e           phase,
    output phase_e           phase_nxt,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    // Last position of each phase; stepping from it enters the following phase.
    localparam logic [CNT_W-1:0] LAST_ACTIVE = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FRONT  = CNT_W'(ACTIVE + FRONT - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC   = CNT_W'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_POS    = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count_q, count_d;
    phase_e           phase_q, phase_d;

    // Current position is the last one of the axis; the next step wraps to 0.
    assign wrap = (count_q == LAST_POS);

    // Next position and phase; both hold unless stepped.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (step) begin
            if (wrap) begin
                count_d = '0;
                phase_d = PH_ACTIVE;
            end else begin
                count_d = count_q + CNT_W'(1);
                case (phase_q)
                    PH_ACTIVE: if (count_q == LAST_ACTIVE) phase_d = PH_FRONT;
                    PH_FRONT:  if (count_q == LAST_FRONT)  phase_d = PH_SYNC;
                    PH_SYNC:   if (count_q == LAST_SYNC)   phase_d = PH_BACK;
                    default:   phase_d = phase_q;
                endcase
            end
        end
    end

    // Position and phase registers with synchronous reset to end of axis.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= LAST_POS;
            phase_q <= PH_BACK;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign count     = count_q;
    assign phase     = phase_q;
    assign phase_nxt = phase_d;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters, syncs, data enable
// and line/frame start pulses, all registered and mutually aligned.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input logic                clk,
    input logic                rst,
    video_timing_gen_if.master vif
);

    // Reject timings with an empty segment or a total the counters cannot hold.
    if (!timing_ok(H_ACTIVE, H_FRONT, H_SYNC, H_BACK)) begin : g_bad_h_timing
        $error("video_timing_gen: illegal horizontal timing parameters");
    end
    if (!timing_ok(V_ACTIVE, V_FRONT, V_SYNC, V_BACK)) begin : g_bad_v_timing
        $error("video_timing_gen: illegal vertical timing parameters");
    end

    logic [CNT_W-1:0] h_count, v_count;
    phase_e           h_phase, h_phase_nxt, v_phase, v_phase_nxt;
    logic             h_wrap, v_wrap;
    logic             v_step;

    // The vertical axis moves once per completed line.
    assign v_step = vif.i_en & h_wrap;

    video_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (vif.i_en),
        .count     (h_count),
        .phase     (h_phase),
        .phase_nxt (h_phase_nxt),
        .wrap      (h_wrap)
    );

    video_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (v_step),
        .count     (v_count),
        .phase     (v_phase),
        .phase_nxt (v_phase_nxt),
        .wrap      (v_wrap)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic de_q, de_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Decode the phases the counters are about to enter so the flags land on
    // the same edge as the counters; pulses only fire on an enabled wrap.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (vif.i_en) begin
            hsync_d       = (h_phase_nxt == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_d       = (v_phase_nxt == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            de_d          = (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
            line_start_d  = h_wrap;
            frame_start_d = h_wrap & v_wrap;
        end
    end

    // Output flag registers; reset matches the parked BACK/BACK position.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vif.o_hcnt        = h_count;
    assign vif.o_vcnt        = v_count;
    assign vif.o_hsync       = hsync_q;
    assign vif.o_vsync       = vsync_q;
    assign vif.o_de          = de_q;
    assign vif.o_line_start  = line_start_q;
    assign vif.o_frame_start = frame_start_q;
    assign vif.dbg_hphase    = h_phase;
    assign vif.dbg_vphase    = v_phase;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default 640x480 instance plus a tiny-raster
// instance, both checked every cycle against a coordinate-based model.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    localparam int W = 27;  // {hcnt, vcnt, hsync, vsync, de, line_start, frame_start}

    // Instance A: default timing, active-low syncs.
    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
    localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
    localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
    // Instance B: tiny raster, active-high HSYNC.
    localparam int B_HA = 4, B_HF = 1, B_HS = 1, B_HB = 1;
    localparam int B_VA = 2, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;
    localparam bit B_HPOL = 1'b1;
    localparam bit B_VPOL = 1'b0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    video_timing_gen_if vif_a ();
    video_timing_gen_if vif_b ();

    video_timing_gen u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .vif (vif_a.master)
    );

    video_timing_gen #(
        .H_ACTIVE (B_HA), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
        .V_ACTIVE (B_VA), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
        .H_SYNC_POL (B_HPOL), .V_SYNC_POL (B_VPOL)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .vif (vif_b.master)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_qa[$];
    logic [W-1:0] exp_qb[$];
    logic [W-1:0] exp_v, act_v;
    int errors = 0;
    int checks = 0;

    int   ma_h, ma_v, mb_h, mb_v;
    logic ma_ls, ma_fs, mb_ls, mb_fs;

    // Expected outputs derived purely from raster coordinates.
    function automatic logic [W-1:0] model_out(
        input int h, input int v, input logic ls, input logic fs,
        input int ha, input int hf, input int hs,
        input int va, input int vf, input int vs,
        input bit hpol, input bit vpol);
        logic hsync, vsync, de;
        hsync = ((h >= ha + hf) && (h < ha + hf + hs)) ? hpol : ~hpol;
        vsync = ((v >= va + vf) && (v < va + vf + vs)) ? vpol : ~vpol;
        de    = (h < ha) && (v < va);
        return {11'(h), 11'(v), hsync, vsync, de, ls, fs};
    endfunction

    function automatic logic [W-1:0] pack_a();
        return {vif_a.o_hcnt, vif_a.o_vcnt, vif_a.o_hsync, vif_a.o_vsync,
                vif_a.o_de, vif_a.o_line_start, vif_a.o_frame_start};
    endfunction

    function automatic logic [W-1:0] pack_b();
        return {vif_b.o_hcnt, vif_b.o_vcnt, vif_b.o_hsync, vif_b.o_vsync,
                vif_b.o_de, vif_b.o_line_start, vif_b.o_frame_start};
    endfunction

    // ---------------- driver tasks ----------------
    // Drive one clock on instance A and push the model's expectation.
    task automatic step_a(input logic r, input logic en);
        rst_a = r;
        vif_a.i_en = en;
        if (r) begin
            ma_h = A_HT - 1; ma_v = A_VT - 1; ma_ls = 1'b0; ma_fs = 1'b0;
        end else if (en) begin
            ma_h++;
            if (ma_h == A_HT) begin
                ma_h = 0;
                ma_v++;
                if (ma_v == A_VT) ma_v = 0;
            end
            ma_ls = (ma_h == 0);
            ma_fs = (ma_h == 0) && (ma_v == 0);
        end else begin
            ma_ls = 1'b0; ma_fs = 1'b0;
        end
        exp_qa.push_back(model_out(ma_h, ma_v, ma_ls, ma_fs, A_HA, A_HF, A_HS,
                                   A_VA, A_VF, A_VS, 1'b0, 1'b0));
        @(posedge clk);
        #1;
    endtask

    // Drive one clock on instance B and push the model's expectation.
    task automatic step_b(input logic r, input logic en);
        rst_b = r;
        vif_b.i_en = en;
        if (r) begin
            mb_h = B_HT - 1; mb_v = B_VT - 1; mb_ls = 1'b0; mb_fs = 1'b0;
        end else if (en) begin
            mb_h++;
            if (mb_h == B_HT) begin
                mb_h = 0;
                mb_v++;
                if (mb_v == B_VT) mb_v = 0;
            end
            mb_ls = (mb_h == 0);
            mb_fs = (mb_h == 0) && (mb_v == 0);
        end else begin
            mb_ls = 1'b0; mb_fs = 1'b0;
        end
        exp_qb.push_back(model_out(mb_h, mb_v, mb_ls, mb_fs, B_HA, B_HF, B_HS,
                                   B_VA, B_VF, B_VS, B_HPOL, B_VPOL));
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] rst_val;
        rst_val = {11'd799, 11'd524, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, (i == 2));  // last cycle: rst and i_en together, reset wins
            exp_v = exp_qa.pop_front(); act_v = pack_a(); checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL reset_sb: got %h expected %h", act_v, exp_v);
            end
        end
        checks++;
        if (pack_a() !== rst_val) begin
            errors++; $display("FAIL reset_value: got %h expected %h", pack_a(), rst_val);
        end
    endtask

    task automatic test_first_pixel();
        logic [W-1:0] first_val;
        first_val = {11'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        step_a(1'b0, 1'b1);
        exp_v = exp_qa.pop_front(); act_v = pack_a(); checks++;
        if (act_v !== exp_v) begin
            errors++; $display("FAIL first_sb: got %h expected %h", act_v, exp_v);
        end
        checks++;
        if (act_v !== first_val) begin
            errors++; $display("FAIL first_pixel: got %h expected %h", act_v, first_val);
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int de_fall_h = -1;
        int ls_at = -1;
        int hs_first = -1;
        for (int i = 1; i <= A_HT; i++) begin
            step_a(1'b0, 1'b1);
            exp_v = exp_qa.pop_front(); act_v = pack_a(); checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL line_sb: cyc %0d got %h expected %h", i, act_v, exp_v);
            end
            if (vif_a.o_hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(vif_a.o_hcnt);
            end
            if (vif_a.o_de === 1'b0 && de_fall_h < 0) de_fall_h = int'(vif_a.o_hcnt);
            if (vif_a.o_line_start === 1'b1 && ls_at < 0) ls_at = i;
        end
        checks++;
        if (hs_low != 96) begin
            errors++; $display("FAIL hsync_width: got %0d expected 96", hs_low);
        end
        checks++;
        if (hs_first != 656) begin
            errors++; $display("FAIL hsync_start: got %0d expected 656", hs_first);
        end
        checks++;
        if (de_fall_h != 640) begin
            errors++; $display("FAIL de_fall: got %0d expected 640", de_fall_h);
        end
        checks++;
        if (ls_at != 800) begin
            errors++; $display("FAIL line_period: got %0d expected 800", ls_at);
        end
    endtask

    task automatic test_en_toggle();
        logic pat [0:7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int fs_cnt = 0;
        step_a(1'b1, 1'b0);  // park at (799,524)
        exp_v = exp_qa.pop_front(); act_v = pack_a(); checks++;
        if (act_v !== exp_v) begin
            errors++; $display("FAIL toggle_park: got %h expected %h", act_v, exp_v);
        end
        for (int i = 0; i < 8; i++) begin
            step_a(1'b0, pat[i]);
            exp_v = exp_qa.pop_front(); act_v = pack_a(); checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL toggle_sb: step %0d got %h expected %h", i, act_v, exp_v);
            end
            if (vif_a.o_frame_start === 1'b1) fs_cnt++;
        end
        checks++;
        if (fs_cnt != 1) begin
            errors++; $display("FAIL toggle_fs_width: got %0d expected 1", fs_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            step_a(1'b0, 1'($urandom_range(0, 1)));
            exp_v = exp_qa.pop_front(); act_v = pack_a(); checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL random_en_a: step %0d got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (ma_h != 300 && guard < 1000) begin
            step_a(1'b0, 1'b1);
            exp_v = exp_qa.pop_front(); act_v = pack_a(); checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL mid_run: got %h expected %h", act_v, exp_v);
            end
            guard++;
        end
        checks++;
        if (guard >= 1000) begin
            errors++; $display("FAIL mid_reach: got %0d steps expected <1000", guard);
        end
        step_a(1'b1, 1'b1);
        exp_v = exp_qa.pop_front(); act_v = pack_a(); checks++;
        if (act_v !== exp_v) begin
            errors++; $display("FAIL mid_reset: got %h expected %h", act_v, exp_v);
        end
        step_a(1'b0, 1'b1);
        exp_v = exp_qa.pop_front(); act_v = pack_a(); checks++;
        if (act_v !== exp_v) begin
            errors++; $display("FAIL mid_restart: got %h expected %h", act_v, exp_v);
        end
        checks++;
        if (vif_a.o_frame_start !== 1'b1 || vif_a.o_hcnt !== 11'd0 || vif_a.o_vcnt !== 11'd0) begin
            errors++; $display("FAIL mid_frame_start: got fs=%b h=%0d v=%0d expected fs=1 h=0 v=0",
                               vif_a.o_frame_start, vif_a.o_hcnt, vif_a.o_vcnt);
        end
    endtask

    task automatic test_small_frame();
        int fs_cyc [$];
        int de_cnt = 0;
        int hs_cnt = 0;
        logic prev_vs;
        step_b(1'b1, 1'b0);
        exp_v = exp_qb.pop_front(); act_v = pack_b(); checks++;
        if (act_v !== exp_v) begin
            errors++; $display("FAIL small_reset: got %h expected %h", act_v, exp_v);
        end
        prev_vs = vif_b.o_vsync;
        for (int i = 1; i <= 3 * B_HT * B_VT + 1; i++) begin
            step_b(1'b0, 1'b1);
            exp_v = exp_qb.pop_front(); act_v = pack_b(); checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL small_sb: cyc %0d got %h expected %h", i, act_v, exp_v);
            end
            if (vif_b.o_frame_start === 1'b1) fs_cyc.push_back(i);
            if (i <= B_HT * B_VT) begin
                if (vif_b.o_de === 1'b1) de_cnt++;
                if (vif_b.o_hsync === 1'b1) hs_cnt++;
            end
            if (vif_b.o_vsync !== prev_vs && vif_b.o_hcnt !== 11'd0) begin
                errors++; $display("FAIL vsync_align: got hcnt %0d expected 0", vif_b.o_hcnt);
            end
            checks++;
            prev_vs = vif_b.o_vsync;
        end
        checks++;
        if (fs_cyc.size() != 4) begin
            errors++; $display("FAIL small_fs_count: got %0d expected 4", fs_cyc.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (fs_cyc[k] - fs_cyc[k-1] != 35) begin
                    errors++; $display("FAIL small_frame_period: got %0d expected 35",
                                       fs_cyc[k] - fs_cyc[k-1]);
                end
            end
        end
        checks++;
        if (de_cnt != 8) begin
            errors++; $display("FAIL small_de_count: got %0d expected 8", de_cnt);
        end
        checks++;
        if (hs_cnt != 5) begin
            errors++; $display("FAIL small_hsync_count: got %0d expected 5", hs_cnt);
        end
        for (int i = 0; i < 200; i++) begin
            step_b(1'($urandom_range(0, 20) == 0), 1'($urandom_range(0, 1)));
            exp_v = exp_qb.pop_front(); act_v = pack_b(); checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL random_b: step %0d got %h expected %h", i, act_v, exp_v);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        vif_a.i_en = 1'b0;
        vif_b.i_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_first_pixel();
        test_line();
        test_en_toggle();
        test_reset_mid();
        test_small_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator for the HDMI pixel pipeline. Produces the horizontal/vertical pixel counters consumed by the sprite and ball drawing blocks, plus the HSYNC, VSYNC and data-enable signals for the TMDS encoder. Drawing blocks depend on two facts: visible pixels occupy counter values starting at 0, and (0,0) marks the start of each frame.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: HSYNC width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: VSYNC width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `H_SYNC_POL`, 0: HSYNC asserted level (0 = active-low).
- `V_SYNC_POL`, 0: VSYNC asserted level.
- `clk`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_en`  in  1  pixel-advance enable; counters hold while low.
- `o_hcnt`  out  11  horizontal pixel counter, range 0..H_TOTAL-1.
- `o_vcnt`  out  11  vertical line counter, range 0..V_TOTAL-1.
- `o_hsync`  out  1  horizontal sync, polarity set by H_SYNC_POL.
- `o_vsync`  out  1  vertical sync, polarity set by V_SYNC_POL.
- `o_de`  out  1  high only inside the visible area.
- `o_line_start`  out  1  one-clk pulse when o_hcnt enters 0.
- `o_frame_start`  out  1  one-clk pulse when (o_hcnt, o_vcnt) enters (0,0).

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL is the vertical sum (default 525).
- Every timing parameter must be ≥1, and each total must be ≤2048. Elaboration fails otherwise.
- Each axis runs a 4-state phase FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - Horizontal boundaries (counter values where the next phase begins): H_ACTIVE, H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC, and H_TOTAL wrapping to 0.
  - The vertical axis uses the same boundaries with the V_ parameters.
- Horizontal axis advances on every enabled cycle.
- At o_hcnt = H_TOTAL-1:
  - o_hcnt wraps to 0.
  - The vertical axis advances once.
  - If o_vcnt = V_TOTAL-1 as well, both counters wrap to 0.
- o_hsync is asserted iff the horizontal FSM is in SYNC. o_vsync is asserted iff the vertical FSM is in SYNC.
  - VSYNC changes only together with an o_hcnt wrap to 0, i.e. it is aligned to line start.
- o_de = (horizontal FSM in ACTIVE) and (vertical FSM in ACTIVE).
- i_en low: all counters, FSM states, syncs and o_de hold. o_line_start and o_frame_start drop to 0 on the next cycle, so neither pulse is ever longer than one clk.
- Reset:
  - Counters are forced to (H_TOTAL-1, V_TOTAL-1); both FSMs go to BACK.
  - o_de=0, both syncs deasserted, both pulses 0.
  - The first enabled cycle after reset therefore yields (0,0) with o_frame_start=1 and o_line_start=1.
  - Reset mid-frame behaves identically; no partial-frame state survives it.
- Arithmetic: counters are 11-bit unsigned and compare only with equality against constant boundaries. No overflow is possible given the ≤2048 check.

## Timing
- Every output is a register updated on the same clk edge; there is no combinational path from any input to any output.
- o_hsync, o_vsync, o_de and both pulses describe the pixel whose coordinates are on o_hcnt/o_vcnt in that same cycle (zero relative skew).
- Latency from i_en rising to the first counter change is 1 clk.
- Rising edge of `rst` is sampled: outputs hold reset values from the edge after rst=1 until the first edge where rst=0 and i_en=1.
- Simultaneous `rst` and `i_en`: reset wins.
- With i_en tied high, the frame period is exactly H_TOTAL×V_TOTAL clks (420000 at default parameters).

## Structure
- Shared package `video_timing_pkg`:
  - phase enum {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}.
  - Counter width constant CNT_W=11.
  - Default 640×480@60 timing constants.
- Sub-module `video_axis_counter`, instantiated twice (horizontal and vertical).
  - Parameters: ACTIVE/FRONT/SYNC/BACK.
  - Inputs: clk, rst, step.
  - Outputs: count, phase, wrap.
  - Horizontal step = i_en. Vertical step = i_en & horizontal wrap.
- Top level: sync polarity, o_de, pulse generation and the parameter checks.

## Test plan
- Reset, then i_en=1 for 1 clk → (0,0), o_frame_start=1, o_line_start=1, o_de=1, o_hsync=1, o_vsync=1 (active-low defaults).
- Free-run one line → o_de falls at o_hcnt=640. o_hsync is low for o_hcnt 656..751 (96 clks). o_line_start is next high at clk 800.
- Free-run one full frame → o_vsync is low for lines 490..491, changing only at o_hcnt=0. The next o_frame_start arrives exactly 420000 clks after the first.
- Toggle i_en 1,0,0,1 around o_hcnt=799, o_vcnt=524 → counters hold during the low cycles. Wrap to (0,0) occurs on the next enabled clk. o_frame_start is high for exactly 1 clk.
- Assert rst for 1 clk at (300,200) → outputs go to (799,524) with o_de=0 and syncs high. The next enabled clk gives (0,0) with o_frame_start=1.
- Parameters H_ACTIVE=4, H_FRONT=1, H_SYNC=1, H_BACK=1, V_ACTIVE=2, V_FRONT=V_SYNC=V_BACK=1 → line period 7, frame period 35 clks, o_de high for 8 clks per frame.
